// File: rtl/y_write_packer.sv
// y_write_packer: packs 16-bit Y elements into 256-bit lines and writes them to consecutive Y SRAM addresses.
// Define Y_WRITE_VERIFY_EN to add a readback compare after each line write (in_readData2 / op_verifyErr).
module y_write_packer #(
   parameter int unsigned ELEM_W         = 16,
   parameter int unsigned ELEMS_PER_LINE = 16,
   parameter int unsigned ADDR_W         = 11
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_start,
   input  logic [ADDR_W-1:0]                in_baseAddr,
   input  logic [ADDR_W-1:0]                in_numLines,
   input  logic                             in_elemValid,
   input  logic [ELEM_W-1:0]                in_elemData,
`ifdef Y_WRITE_VERIFY_EN
   input  logic [ELEM_W*ELEMS_PER_LINE-1:0] in_readData2,
   output logic                             op_verifyErr,
`endif
   output logic                             op_elemReady,
   output logic                             op_yWriteModuleEnable,
   output logic [ADDR_W-1:0]                op_writePathReadAddr1,
   output logic [ADDR_W-1:0]                op_writePathReadAddr2,
   output logic                             op_writePathWE,
   output logic [ADDR_W-1:0]                op_writePathWriteAddr,
   output logic [ELEM_W*ELEMS_PER_LINE-1:0] op_writePathWriteData,
   output logic                             op_busy,
   output logic                             op_done
);

   localparam int unsigned      LINE_W    = ELEM_W * ELEMS_PER_LINE;
   localparam int unsigned      CNT_W     = (ELEMS_PER_LINE > 1) ? $clog2(ELEMS_PER_LINE) : 1;
   localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(ELEMS_PER_LINE - 1);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
`ifdef Y_WRITE_VERIFY_EN
      , VERIFY
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    elem_q, elem_d;
   logic [ADDR_W-1:0]   lidx_q, lidx_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [LINE_W-1:0]   buf_q, buf_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                last_line;
`ifdef Y_WRITE_VERIFY_EN
   logic [ADDR_W-1:0]   raddr2_q, raddr2_d;
   logic                vph_q, vph_d;
   logic                verr_q, verr_d;
`endif

   assign last_line = (lidx_q == cnt_q - ADDR_W'(1));

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      lidx_d  = lidx_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
`ifdef Y_WRITE_VERIFY_EN
      raddr2_d = raddr2_q;
      vph_d    = vph_q;
      verr_d   = verr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_start) begin
               base_d  = in_baseAddr;
               cnt_d   = in_numLines;
               lidx_d  = '0;
               elem_d  = '0;
               state_d = (in_numLines == '0) ? DONE : FILL;
`ifdef Y_WRITE_VERIFY_EN
               verr_d  = 1'b0;
`endif
            end
         end
         FILL: begin
            if (in_elemValid && ready_q) begin
               for (int unsigned k = 0; k < ELEMS_PER_LINE; k++) begin
                  if (elem_q == CNT_W'(k)) buf_d[k*ELEM_W +: ELEM_W] = in_elemData;
               end
               if (elem_q == LAST_ELEM) begin
                  elem_d  = '0;
                  state_d = WRITE;
                  waddr_d = base_q + lidx_q;
                  wdata_d = buf_d;
               end else begin
                  elem_d = elem_q + CNT_W'(1);
               end
            end
         end
         WRITE: begin
`ifdef Y_WRITE_VERIFY_EN
            state_d  = VERIFY;
            raddr2_d = waddr_q;
            vph_d    = 1'b0;
`else
            lidx_d  = lidx_q + ADDR_W'(1);
            state_d = last_line ? DONE : FILL;
`endif
         end
`ifdef Y_WRITE_VERIFY_EN
         // Phase 0 presents the read address; phase 1 sees the data after the SRAM's one-cycle latency.
         VERIFY: begin
            vph_d = ~vph_q;
            if (vph_q) begin
               if (in_readData2 != wdata_q) verr_d = 1'b1;
               raddr2_d = '1;
               lidx_d   = lidx_q + ADDR_W'(1);
               state_d  = last_line ? DONE : FILL;
            end
         end
`endif
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == FILL);
      busy_d  = (state_d != IDLE) && (state_d != DONE);
      done_d  = (state_d == DONE);
      we_d    = (state_d == WRITE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         elem_q  <= '0;
         lidx_q  <= '0;
         base_q  <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '1;
         wdata_q <= '0;
`ifdef Y_WRITE_VERIFY_EN
         raddr2_q <= '1;
         vph_q    <= 1'b0;
         verr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         lidx_q  <= lidx_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
`ifdef Y_WRITE_VERIFY_EN
         raddr2_q <= raddr2_d;
         vph_q    <= vph_d;
         verr_q   <= verr_d;
`endif
      end
   end

   assign op_elemReady          = ready_q;
   assign op_busy               = busy_q;
   assign op_yWriteModuleEnable = busy_q;
   assign op_done               = done_q;
   assign op_writePathWE        = we_q;
   assign op_writePathWriteAddr = waddr_q;
   assign op_writePathWriteData = wdata_q;
   assign op_writePathReadAddr1 = '1;
`ifdef Y_WRITE_VERIFY_EN
   assign op_writePathReadAddr2 = raddr2_q;
   assign op_verifyErr          = verr_q;
`else
   assign op_writePathReadAddr2 = '1;
`endif

endmodule
